tlb_array: RTL and testbench
============================

Name: tlb_array

Overview:
- Responder end of the writeback-stage TLB interface.
- Holds the 16-entry fully-associative LoongArch TLB.
- Serves two concurrent lookups: s0 for fetch; s1 for load/store and tlbsrch/invtlb.
- Also serves the tlbwr/tlbfill write port, the tlbrd read port, and the invtlb invalidate command.
- Sits beside the CSR file, between the IF/EX address paths and the WB stage.

Parameters:
TLBNUM, 16, number of entries.
TLBIDLEN, 4, index width, equal to clog2(TLBNUM).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s0_vppn / s1_vppn  in  19 each  lookup VA[31:13]
s0_va_bit12 / s1_va_bit12  in  1 each  VA[12], selects odd/even page for 4KB entries
s0_asid / s1_asid  in  10 each  current ASID; s1 values also serve as invtlb operands
s0_found / s1_found  out  1 each  hit
s0_index / s1_index  out  TLBIDLEN each  hit entry index
s0_ppn / s1_ppn  out  20 each  selected-page PPN
s0_ps / s1_ps  out  6 each  page size
s0_plv, s0_mat / s1_plv, s1_mat  out  2 each  privilege, memory type
s0_d, s0_v / s1_d, s1_v  out  1 each  dirty, valid
invtlb_valid  in  1  invtlb command strobe
invtlb_op  in  5  invtlb operation code
we  in  1  write strobe (tlbwr/tlbfill)
w_index  in  TLBIDLEN  write target entry
w_e, w_g  in  1 each  exist bit, global bit
w_vppn  in  19  entry VPPN
w_ps  in  6  entry page size
w_asid  in  10  entry ASID
w_ppn0, w_ppn1  in  20 each  even/odd page PPN
w_plv0, w_mat0, w_plv1, w_mat1  in  2 each  even/odd page PLV, MAT
w_d0, w_v0, w_d1, w_v1  in  1 each  even/odd page D, V
r_index  in  TLBIDLEN  read entry
r_e, r_g, r_d0, r_v0, r_d1, r_v1  out  1 each  read fields
r_vppn  out  19  read VPPN
r_ps  out  6  read page size
r_asid  out  10  read ASID
r_ppn0, r_ppn1  out  20 each  read PPNs
r_plv0, r_mat0, r_plv1, r_mat1  out  2 each  read PLVs, MATs

Behaviour:
- Storage: per-entry registers e, vppn, ps, asid, g, and page0/page1 {ppn, plv, mat, d, v}.
- Reset clears every field of every entry to 0; consequently s*_found=0 and all r_* outputs read 0 after reset.
- Page-size rule: ps==21 is a 2MB entry; any other value is treated as 4KB.
- Match for entry i: e && (g || asid==s_asid) && vppn compare.
  - 4KB compare: vppn[18:0].
  - 2MB compare: vppn[18:9] only.
- Odd-page select: va_bit12 for 4KB entries; vppn[8] for 2MB entries.
- Lookups and reads are purely combinational, zero latency.
  - Multiple hits: lowest index wins.
  - Miss: found=0, index=0, all data outputs 0.
- Write: on the clk edge with we=1, entry[w_index] <= w_* fields. Same-cycle lookups and reads see the old contents.
- invtlb: on the clk edge with invtlb_valid=1, clear e of each entry meeting the op's predicate. VPPN matching follows each entry's ps rule.
  - op 0, 1: all entries.
  - op 2: g=1.
  - op 3: g=0.
  - op 4: g=0 && asid==s1_asid.
  - op 5: g=0 && asid==s1_asid && vppn match with s1_vppn.
  - op 6: (g=1 || asid==s1_asid) && vppn match with s1_vppn.
  - op >=7: no change; the exception is raised upstream.
- we and invtlb_valid in the same cycle:
  - The write to w_index wins for that entry; its e = w_e.
  - invtlb applies to all other entries.
- reset asserted in the same cycle as we or invtlb_valid: reset wins and all entries are cleared.

Decomposition:
- Shared package tlb_defs holds:
  - constants PS_4K=12 and PS_2M=21;
  - INVTLB_OP_* codes 0..6;
  - the entry field widths (VPPN 19, PPN 20, ASID 10, PS 6).
- Sub-module tlb_match, instantiated twice (s0, s1): per-entry match vector, lowest-index priority encoder, and odd/even page mux.

Test Plan:
1. After reset, look up s0_vppn=0x00000, asid=0 -> s0_found=0; r_index=3 -> r_e=0, r_vppn=0.
2. Write idx5: vppn=0x12345, ps=12, asid=0x1, g=0, ppn0=0xAAAAA, ppn1=0xBBBBB, v0=v1=1. Next cycle, s1_vppn=0x12345, asid=0x1 -> found=1, index=5.
   - va_bit12=0 -> ppn=0xAAAAA; va_bit12=1 -> ppn=0xBBBBB.
   - asid=0x2 -> found=0.
3. Write idx2: ps=21, g=1, vppn=0x2A000, ppn1=0x00200. Look up vppn=0x2A1FF, any asid -> found=1, index=2, ppn=0x00200 (vppn[8]=1 selects odd).
4. Entries 4 and 9 both match vppn 0x00100 -> s0_index=4. Same cycle, s1 looking up a different VPPN still returns its own entry.
5. Load entries 1(g=1), 2(g=0, asid 7), 3(g=0, asid 8).
   - invtlb op4 with s1_asid=7 -> only entry 2 loses e.
   - Then op2 -> entry 1 cleared, entry 3 kept.
   - Then op9 -> no change.
6. Same cycle: we on idx6 with w_e=1, plus invtlb op0 -> afterwards only entry 6 has e=1. A lookup in that same cycle returns the pre-edge contents.

Source files
------------

// File: rtl/tlb_array_pkg.sv
// Shared TLB definitions: field widths, page-size codes, invtlb op codes,
// entry/page record types and the match helpers used by lookup and invtlb.
package tlb_defs;

  localparam int VPPN_W = 19;
  localparam int PPN_W  = 20;
  localparam int ASID_W = 10;
  localparam int PS_W   = 6;

  localparam logic [PS_W-1:0] PS_4K = 6'd12;
  localparam logic [PS_W-1:0] PS_2M = 6'd21;

  localparam logic [4:0] INVTLB_OP_ALL0     = 5'd0;
  localparam logic [4:0] INVTLB_OP_ALL1     = 5'd1;
  localparam logic [4:0] INVTLB_OP_G        = 5'd2;
  localparam logic [4:0] INVTLB_OP_NG       = 5'd3;
  localparam logic [4:0] INVTLB_OP_ASID     = 5'd4;
  localparam logic [4:0] INVTLB_OP_ASID_VA  = 5'd5;
  localparam logic [4:0] INVTLB_OP_GASID_VA = 5'd6;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [1:0]       plv;
    logic [1:0]       mat;
    logic             d;
    logic             v;
  } tlb_page_t;

  typedef struct packed {
    logic              e;
    logic              g;
    logic [VPPN_W-1:0] vppn;
    logic [PS_W-1:0]   ps;
    logic [ASID_W-1:0] asid;
    tlb_page_t         p0;
    tlb_page_t         p1;
  } tlb_entry_t;

  // A 2MB entry ignores the low 9 VPPN bits; anything else compares all 19.
  function automatic logic vppn_match(input logic [PS_W-1:0] ps,
                                      input logic [VPPN_W-1:0] e_vppn,
                                      input logic [VPPN_W-1:0] s_vppn);
    if (ps == PS_2M) return e_vppn[18:9] == s_vppn[18:9];
    return e_vppn == s_vppn;
  endfunction

  // True when an invtlb with the given op should drop this entry's e bit.
  function automatic logic invtlb_hit(input logic [4:0] op, input tlb_entry_t ent,
                                      input logic [ASID_W-1:0] asid,
                                      input logic [VPPN_W-1:0] vppn);
    logic asid_hit;
    logic va_hit;
    asid_hit = ent.asid == asid;
    va_hit   = vppn_match(ent.ps, ent.vppn, vppn);
    case (op)
      INVTLB_OP_ALL0, INVTLB_OP_ALL1: return 1'b1;
      INVTLB_OP_G:        return ent.g;
      INVTLB_OP_NG:       return !ent.g;
      INVTLB_OP_ASID:     return !ent.g && asid_hit;
      INVTLB_OP_ASID_VA:  return !ent.g && asid_hit && va_hit;
      INVTLB_OP_GASID_VA: return (ent.g || asid_hit) && va_hit;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tlb_array_match.sv
// One TLB lookup port: per-entry hit vector, lowest-index priority pick,
// and odd/even page selection. Purely combinational.
module tlb_match
  import tlb_defs::*;
#(
  parameter int TLBNUM   = 16,
  parameter int TLBIDLEN = 4
) (
  input  tlb_entry_t [TLBNUM-1:0] entries,
  input  logic [VPPN_W-1:0]       vppn,
  input  logic                    va_bit12,
  input  logic [ASID_W-1:0]       asid,
  output logic                    found,
  output logic [TLBIDLEN-1:0]     index,
  output tlb_page_t               page,
  output logic [PS_W-1:0]         ps
);

  logic [TLBNUM-1:0] hit;
  tlb_entry_t        sel;
  logic              odd;

  for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_hit
    assign hit[gi] = entries[gi].e &&
                     (entries[gi].g || entries[gi].asid == asid) &&
                     vppn_match(entries[gi].ps, entries[gi].vppn, vppn);
  end

  // Priority encoder: scanning downwards leaves the lowest hitting index.
  always_comb begin
    found = |hit;
    index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit[i]) index = TLBIDLEN'(i);
    end
  end

  // Page mux: 2MB entries split on VA bit 21 (vppn[8]), 4KB entries on VA bit 12.
  always_comb begin
    sel  = entries[index];
    odd  = (sel.ps == PS_2M) ? vppn[8] : va_bit12;
    page = '0;
    ps   = '0;
    if (found) begin
      page = odd ? sel.p1 : sel.p0;
      ps   = sel.ps;
    end
  end

endmodule

// File: rtl/tlb_array.sv
// 16-entry fully-associative TLB: two lookup ports, tlbrd read port,
// tlbwr/tlbfill write port and invtlb invalidation.
module tlb_array
  import tlb_defs::*;
#(
  parameter int TLBNUM   = 16,
  parameter int TLBIDLEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [VPPN_W-1:0]   s0_vppn,
  input  logic                s0_va_bit12,
  input  logic [ASID_W-1:0]   s0_asid,
  output logic                s0_found,
  output logic [TLBIDLEN-1:0] s0_index,
  output logic [PPN_W-1:0]    s0_ppn,
  output logic [PS_W-1:0]     s0_ps,
  output logic [1:0]          s0_plv,
  output logic [1:0]          s0_mat,
  output logic                s0_d,
  output logic                s0_v,
  input  logic [VPPN_W-1:0]   s1_vppn,
  input  logic                s1_va_bit12,
  input  logic [ASID_W-1:0]   s1_asid,
  output logic                s1_found,
  output logic [TLBIDLEN-1:0] s1_index,
  output logic [PPN_W-1:0]    s1_ppn,
  output logic [PS_W-1:0]     s1_ps,
  output logic [1:0]          s1_plv,
  output logic [1:0]          s1_mat,
  output logic                s1_d,
  output logic                s1_v,
  input  logic                invtlb_valid,
  input  logic [4:0]          invtlb_op,
  input  logic                we,
  input  logic [TLBIDLEN-1:0] w_index,
  input  logic                w_e,
  input  logic                w_g,
  input  logic [VPPN_W-1:0]   w_vppn,
  input  logic [PS_W-1:0]     w_ps,
  input  logic [ASID_W-1:0]   w_asid,
  input  logic [PPN_W-1:0]    w_ppn0,
  input  logic [1:0]          w_plv0,
  input  logic [1:0]          w_mat0,
  input  logic                w_d0,
  input  logic                w_v0,
  input  logic [PPN_W-1:0]    w_ppn1,
  input  logic [1:0]          w_plv1,
  input  logic [1:0]          w_mat1,
  input  logic                w_d1,
  input  logic                w_v1,
  input  logic [TLBIDLEN-1:0] r_index,
  output logic                r_e,
  output logic                r_g,
  output logic [VPPN_W-1:0]   r_vppn,
  output logic [PS_W-1:0]     r_ps,
  output logic [ASID_W-1:0]   r_asid,
  output logic [PPN_W-1:0]    r_ppn0,
  output logic [1:0]          r_plv0,
  output logic [1:0]          r_mat0,
  output logic                r_d0,
  output logic                r_v0,
  output logic [PPN_W-1:0]    r_ppn1,
  output logic [1:0]          r_plv1,
  output logic [1:0]          r_mat1,
  output logic                r_d1,
  output logic                r_v1
);

  tlb_entry_t [TLBNUM-1:0] entry_q;
  tlb_entry_t [TLBNUM-1:0] entry_d;
  tlb_entry_t              rd;
  tlb_page_t               s0_page;
  tlb_page_t               s1_page;

  // Next contents: invtlb drops e bits first, then a write overrides its target entry.
  always_comb begin
    entry_d = entry_q;
    if (invtlb_valid) begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (invtlb_hit(invtlb_op, entry_q[i], s1_asid, s1_vppn)) entry_d[i].e = 1'b0;
      end
    end
    if (we) begin
      entry_d[w_index] = '{e: w_e, g: w_g, vppn: w_vppn, ps: w_ps, asid: w_asid,
                           p0: '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0},
                           p1: '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1}};
    end
  end

  // Entry storage; reset has priority over any same-cycle write or invalidate.
  always_ff @(posedge clk) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  tlb_match #(.TLBNUM(TLBNUM), .TLBIDLEN(TLBIDLEN)) u_s0 (
    .entries(entry_q), .vppn(s0_vppn), .va_bit12(s0_va_bit12), .asid(s0_asid),
    .found(s0_found), .index(s0_index), .page(s0_page), .ps(s0_ps)
  );

  tlb_match #(.TLBNUM(TLBNUM), .TLBIDLEN(TLBIDLEN)) u_s1 (
    .entries(entry_q), .vppn(s1_vppn), .va_bit12(s1_va_bit12), .asid(s1_asid),
    .found(s1_found), .index(s1_index), .page(s1_page), .ps(s1_ps)
  );

  assign s0_ppn = s0_page.ppn;
  assign s0_plv = s0_page.plv;
  assign s0_mat = s0_page.mat;
  assign s0_d   = s0_page.d;
  assign s0_v   = s0_page.v;
  assign s1_ppn = s1_page.ppn;
  assign s1_plv = s1_page.plv;
  assign s1_mat = s1_page.mat;
  assign s1_d   = s1_page.d;
  assign s1_v   = s1_page.v;

  assign rd     = entry_q[r_index];
  assign r_e    = rd.e;
  assign r_g    = rd.g;
  assign r_vppn = rd.vppn;
  assign r_ps   = rd.ps;
  assign r_asid = rd.asid;
  assign r_ppn0 = rd.p0.ppn;
  assign r_plv0 = rd.p0.plv;
  assign r_mat0 = rd.p0.mat;
  assign r_d0   = rd.p0.d;
  assign r_v0   = rd.p0.v;
  assign r_ppn1 = rd.p1.ppn;
  assign r_plv1 = rd.p1.plv;
  assign r_mat1 = rd.p1.mat;
  assign r_d1   = rd.p1.d;
  assign r_v1   = rd.p1.v;

endmodule

// File: tb/tb_tlb_array.sv
// Self-checking bench for tlb_array: directed scenarios plus randomized
// write/invtlb/lookup traffic against an array-based reference TLB.
module tb_tlb_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vppn, s1_vppn;
  logic        s0_va_bit12, s1_va_bit12;
  logic [9:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found, s0_d, s0_v, s1_d, s1_v;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0]  s0_ps, s1_ps;
  logic [1:0]  s0_plv, s0_mat, s1_plv, s1_mat;
  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic        we;
  logic [3:0]  w_index, r_index;
  logic        w_e, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [18:0] w_vppn;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
  logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;

  typedef struct packed { bit [19:0] ppn; bit [1:0] plv; bit [1:0] mat; bit d; bit v; } pg_t;
  typedef struct packed {
    bit e; bit g; bit [18:0] vppn; bit [5:0] ps; bit [9:0] asid; pg_t p0; pg_t p1;
  } ent_t;

  ent_t        mdl [16];
  ent_t        wr;
  int          n_vec = 0;
  int          n_bad = 0;
  bit   [18:0] pool [4] = '{19'h12345, 19'h2A000, 19'h00100, 19'h7FFFF};
  bit   [5:0]  ps_pool [3] = '{6'd12, 6'd21, 6'd14};

  always #5 clk = ~clk;

  assign w_e = wr.e;          assign w_g = wr.g;
  assign w_vppn = wr.vppn;    assign w_ps = wr.ps;        assign w_asid = wr.asid;
  assign w_ppn0 = wr.p0.ppn;  assign w_plv0 = wr.p0.plv;  assign w_mat0 = wr.p0.mat;
  assign w_d0 = wr.p0.d;      assign w_v0 = wr.p0.v;
  assign w_ppn1 = wr.p1.ppn;  assign w_plv1 = wr.p1.plv;  assign w_mat1 = wr.p1.mat;
  assign w_d1 = wr.p1.d;      assign w_v1 = wr.p1.v;

  tlb_array dut (
    .clk(clk), .reset(reset),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
    .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
    .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .we(we), .w_index(w_index), .w_e(w_e), .w_g(w_g), .w_vppn(w_vppn), .w_ps(w_ps),
    .w_asid(w_asid), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0),
    .w_v0(w_v0), .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1),
    .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_g(r_g), .r_vppn(r_vppn), .r_ps(r_ps),
    .r_asid(r_asid), .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0),
    .r_v0(r_v0), .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1),
    .r_v1(r_v1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference lookup: first entry (lowest index) satisfying the match rule.
  function automatic logic [36:0] ref_lookup(input bit [18:0] va, input bit b12, input bit [9:0] as);
    bit  big;
    bit  vm;
    pg_t p;
    for (int i = 0; i < 16; i++) begin
      big = (mdl[i].ps == 6'd21);
      vm  = big ? (mdl[i].vppn[18:9] == va[18:9]) : (mdl[i].vppn == va);
      if (mdl[i].e && (mdl[i].g || mdl[i].asid == as) && vm) begin
        p = (big ? va[8] : b12) ? mdl[i].p1 : mdl[i].p0;
        return {1'b1, 4'(i), p.ppn, mdl[i].ps, p.plv, p.mat, p.d, p.v};
      end
    end
    return '0;
  endfunction

  function automatic bit ref_inv(input int i);
    bit big;
    bit vm;
    bit am;
    big = (mdl[i].ps == 6'd21);
    vm  = big ? (mdl[i].vppn[18:9] == s1_vppn[18:9]) : (mdl[i].vppn == s1_vppn);
    am  = (mdl[i].asid == s1_asid);
    case (invtlb_op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return mdl[i].g;
      5'd3:       return !mdl[i].g;
      5'd4:       return !mdl[i].g && am;
      5'd5:       return !mdl[i].g && am && vm;
      5'd6:       return (mdl[i].g || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic check_ports(input string tag);
    check({tag, "_s0"}, {s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v},
          ref_lookup(s0_vppn, s0_va_bit12, s0_asid));
    check({tag, "_s1"}, {s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v},
          ref_lookup(s1_vppn, s1_va_bit12, s1_asid));
    check({tag, "_rd"}, {r_e, r_g, r_vppn, r_ps, r_asid, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
                         r_ppn1, r_plv1, r_mat1, r_d1, r_v1}, mdl[r_index]);
  endtask

  // Apply one clock edge to both the DUT and the reference, then drop strobes.
  task automatic tick();
    ent_t nxt [16];
    for (int i = 0; i < 16; i++) begin
      nxt[i] = mdl[i];
      if (invtlb_valid && ref_inv(i)) nxt[i].e = 1'b0;
    end
    if (we) nxt[w_index] = wr;
    @(posedge clk);
    for (int i = 0; i < 16; i++) mdl[i] = reset ? ent_t'(0) : nxt[i];
    #1;
    we = 1'b0;
    invtlb_valid = 1'b0;
  endtask

  task automatic write(input int idx, input ent_t ent);
    wr = ent;
    w_index = 4'(idx);
    we = 1'b1;
    tick();
  endtask

  task automatic read_e(input string tag, input int idx, input bit exp);
    r_index = 4'(idx);
    #1;
    check(tag, r_e, exp);
  endtask

  function automatic bit [18:0] pick_vppn();
    bit [18:0] v;
    v = pool[$urandom_range(0, 3)];
    if ($urandom_range(0, 1) == 1) v[8:0] = 9'($urandom);
    return v;
  endfunction

  initial begin
    ent_t        t;
    logic [95:0] rnd;
    reset = 1'b1; we = 1'b0; invtlb_valid = 1'b0; invtlb_op = '0;
    wr = '0; w_index = '0; r_index = '0;
    s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
    s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state
    r_index = 4'd3;
    #1;
    check("t1_s0_found", s0_found, 1'b0);
    check("t1_r_e", r_e, 1'b0);
    check("t1_r_vppn", r_vppn, 19'h0);
    check_ports("t1");

    // 2: 4KB entry at index 5, odd/even select, ASID mismatch
    t = '0; t.e = 1; t.vppn = 19'h12345; t.ps = 6'd12; t.asid = 10'h1;
    t.p0.ppn = 20'hAAAAA; t.p1.ppn = 20'hBBBBB; t.p0.v = 1; t.p1.v = 1;
    write(5, t);
    s1_vppn = 19'h12345; s1_asid = 10'h1; s1_va_bit12 = 1'b0;
    #1;
    check("t2_found", s1_found, 1'b1);
    check("t2_index", s1_index, 4'd5);
    check("t2_ppn_even", s1_ppn, 20'hAAAAA);
    s1_va_bit12 = 1'b1;
    #1;
    check("t2_ppn_odd", s1_ppn, 20'hBBBBB);
    s1_asid = 10'h2;
    #1;
    check("t2_asid_miss", s1_found, 1'b0);
    check_ports("t2");

    // 3: 2MB global entry at index 2, odd page chosen by vppn[8]
    t = '0; t.e = 1; t.g = 1; t.vppn = 19'h2A000; t.ps = 6'd21; t.p1.ppn = 20'h00200; t.p1.v = 1;
    write(2, t);
    s1_vppn = 19'h2A1FF; s1_asid = 10'h3FF; s1_va_bit12 = 1'b0;
    #1;
    check("t3_found", s1_found, 1'b1);
    check("t3_index", s1_index, 4'd2);
    check("t3_ppn", s1_ppn, 20'h00200);

    // 4: duplicate match resolves to lowest index; s1 independent
    t = '0; t.e = 1; t.g = 1; t.vppn = 19'h00100; t.ps = 6'd12; t.p0.ppn = 20'h44444;
    write(9, t);
    t.p0.ppn = 20'h99999;
    write(4, t);
    s0_vppn = 19'h00100; s0_asid = 10'h0; s0_va_bit12 = 1'b0;
    s1_vppn = 19'h12345; s1_asid = 10'h1;
    #1;
    check("t4_s0_index", s0_index, 4'd4);
    check("t4_s1_index", s1_index, 4'd5);
    check_ports("t4");

    // 5: invtlb op4, op2, op9
    t = '0; t.e = 1; t.g = 1; t.vppn = 19'h11111; t.ps = 6'd12;
    write(1, t);
    t.g = 0; t.asid = 10'd7; write(2, t);
    t.asid = 10'd8; write(3, t);
    s1_asid = 10'd7; invtlb_op = 5'd4; invtlb_valid = 1'b1; tick();
    read_e("t5_op4_e1", 1, 1'b1); read_e("t5_op4_e2", 2, 1'b0); read_e("t5_op4_e3", 3, 1'b1);
    invtlb_op = 5'd2; invtlb_valid = 1'b1; tick();
    read_e("t5_op2_e1", 1, 1'b0); read_e("t5_op2_e3", 3, 1'b1);
    invtlb_op = 5'd9; invtlb_valid = 1'b1; tick();
    read_e("t5_op9_e3", 3, 1'b1); read_e("t5_op9_e5", 5, 1'b1);

    // 6: write + invtlb op0 in one cycle; same-cycle lookup sees old contents
    t = '0; t.e = 1; t.vppn = 19'h06666; t.ps = 6'd12; t.asid = 10'h1;
    wr = t; w_index = 4'd6; we = 1'b1; invtlb_op = 5'd0; invtlb_valid = 1'b1;
    s1_vppn = 19'h12345; s1_asid = 10'h1;
    #1;
    check("t6_pre_found", s1_found, 1'b1);
    check("t6_pre_index", s1_index, 4'd5);
    tick();
    for (int i = 0; i < 16; i++) read_e($sformatf("t6_e%0d", i), i, i == 6);

    // Randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      rnd = {$urandom, $urandom, $urandom};
      t = ent_t'(rnd[88:0]);
      t.vppn = pick_vppn();
      t.asid = 10'($urandom_range(0, 3));
      t.ps = ps_pool[$urandom_range(0, 2)];
      t.e = ($urandom_range(0, 3) != 0);
      wr = t;
      w_index = 4'($urandom);
      we = ($urandom_range(0, 1) == 1);
      invtlb_valid = ($urandom_range(0, 4) == 0);
      invtlb_op = 5'($urandom_range(0, 9));
      s0_vppn = pick_vppn(); s0_va_bit12 = 1'($urandom); s0_asid = 10'($urandom_range(0, 3));
      s1_vppn = pick_vppn(); s1_va_bit12 = 1'($urandom); s1_asid = 10'($urandom_range(0, 3));
      r_index = 4'($urandom);
      #1;
      check_ports($sformatf("rnd%0d_pre", n));
      tick();
      check_ports($sformatf("rnd%0d_post", n));
    end

    // Reset dominates a same-cycle write and invalidate
    t.e = 1; wr = t; w_index = 4'd7; we = 1'b1;
    invtlb_valid = 1'b1; invtlb_op = 5'd3; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i);
      #1;
      check($sformatf("rst_rd%0d", i),
            {r_e, r_g, r_vppn, r_ps, r_asid, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
             r_ppn1, r_plv1, r_mat1, r_d1, r_v1}, 89'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
